// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
//   Carries a packed control word through STAGES pipeline registers
//   (stage 0 youngest, fed from Decode). Each stage can be stalled (hold)
//   or flushed (clear to NOP) independently. A bubble is inserted
//   automatically behind a stage that holds. A saturating counter reports
//   how many cycles inserted at least one bubble.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous, active-high
//   in_data_i     : control word from Decode
//   in_valid_i    : in_data_i is a real instruction
//   stall_i[i]    : hold stage i
//   flush_i[i]    : clear stage i to NOP (beats stall)
//   cnt_clr_i     : synchronous clear of the bubble counter
//   stage_data_o  : stage i at [i*WIDTH +: WIDTH]
//   stage_valid_o : valid bit per stage
//   bubble_cnt_o  : saturating count of bubble-inserting cycles

module ctrl_pipe_chain #(
    parameter int               STAGES  = 3,
    parameter int               WIDTH   = 10,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data_i,
    input  logic                      in_valid_i,
    input  logic [STAGES-1:0]         stall_i,
    input  logic [STAGES-1:0]         flush_i,
    input  logic                      cnt_clr_i,
    output logic [STAGES*WIDTH-1:0]   stage_data_o,
    output logic [STAGES-1:0]         stage_valid_o,
    output logic [CNT_W-1:0]          bubble_cnt_o
);

    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            bubble;

    // A stage only really holds its word when it is stalled and not
    // flushed; a flushed stage lets its old word move on, so the stage
    // behind it loads that word rather than taking a bubble.
    logic [STAGES-1:0]            hold;
    assign hold = stall_i & ~flush_i;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic             up_vld;
        logic             up_hold;
        logic [WIDTH-1:0] d_d, d_q;
        logic             v_d, v_q;
        logic             bub;

        if (g == 0) begin : g_head
            assign up_hold = 1'b0;
            assign up_data = in_valid_i ? in_data_i : NOP_VAL;
            assign up_vld  = in_valid_i;
        end else begin : g_body
            assign up_hold = hold[g-1];
            assign up_data = data_q[g-1];
            assign up_vld  = vld_q[g-1];
        end

        always_comb begin
            d_d = d_q;
            v_d = v_q;
            bub = 1'b0;
            if (flush_i[g]) begin
                d_d = NOP_VAL;
                v_d = 1'b0;
            end else if (stall_i[g]) begin
                d_d = d_q;
                v_d = v_q;
            end else if (up_hold) begin
                d_d = NOP_VAL;
                v_d = 1'b0;
                bub = 1'b1;
            end else begin
                d_d = up_data;
                v_d = up_vld;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                d_q <= NOP_VAL;
                v_q <= 1'b0;
            end else begin
                d_q <= d_d;
                v_q <= v_d;
            end
        end

        assign data_q[g]                          = d_q;
        assign vld_q[g]                           = v_q;
        assign bubble[g]                          = bub;
        assign stage_data_o[g*WIDTH +: WIDTH]     = d_q;
        assign stage_valid_o[g]                   = v_q;
    end

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (|bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
module tb_ctrl_pipe_chain;

    localparam int S = 3;
    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic           cnt_clr;
    logic [S*W-1:0] stage_data;
    logic [S-1:0]   stage_valid;
    logic [C-1:0]   bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [W-1:0] m_d [S];
    logic         m_v [S];
    int           m_cnt;

    ctrl_pipe_chain #(.STAGES(S), .WIDTH(W), .NOP_VAL(8'h00), .CNT_W(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .stall_i      (stall),
        .flush_i      (flush),
        .cnt_clr_i    (cnt_clr),
        .stage_data_o (stage_data),
        .stage_valid_o(stage_valid),
        .bubble_cnt_o (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [S*W-1:0] m_data_pk();
        return {m_d[2], m_d[1], m_d[0]};
    endfunction

    function automatic logic [S-1:0] m_vld_pk();
        return {m_v[2], m_v[1], m_v[0]};
    endfunction

    // Advance the reference by one edge using the currently driven inputs,
    // then let the DUT take the same edge and settle.
    task automatic cyc();
        logic [W-1:0] nd [S];
        logic         nv [S];
        logic         bub;
        bub = 1'b0;
        for (int i = 0; i < S; i++) begin
            int up;
            up = (i > 0) ? i - 1 : 0;
            if (reset || flush[i]) begin
                nd[i] = 8'h00; nv[i] = 1'b0;
            end else if (stall[i]) begin
                nd[i] = m_d[i]; nv[i] = m_v[i];
            end else if (i > 0 && stall[up] && !flush[up]) begin
                nd[i] = 8'h00; nv[i] = 1'b0; bub = 1'b1;
            end else if (i == 0) begin
                nd[i] = in_valid ? in_data : 8'h00; nv[i] = in_valid;
            end else begin
                nd[i] = m_d[up]; nv[i] = m_v[up];
            end
        end
        if (reset || cnt_clr) m_cnt = 0;
        else if (bub && m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
        for (int i = 0; i < S; i++) begin
            m_d[i] = nd[i]; m_v[i] = nv[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; in_data = '0; in_valid = 1'b0;
        stall = '0; flush = '0; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (stage_data !== 24'h000000) begin n_err++; $display("FAIL reset_data got %h want 000000", stage_data); end
        n_cmp++; if (stage_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid got %b want 000", stage_valid); end
        n_cmp++; if (bubble_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_stream();
        logic [W-1:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = words[k];
            cyc();
        end
        n_cmp++; if (stage_data !== 24'h112233) begin n_err++; $display("FAIL stream_data got %h want 112233", stage_data); end
        n_cmp++; if (stage_valid !== 3'b111) begin n_err++; $display("FAIL stream_valid got %b want 111", stage_valid); end
    endtask

    task automatic test_stall_bubble();
        in_valid = 1'b0; in_data = 8'hA5;
        stall = 3'b001;
        cyc();
        n_cmp++; if (stage_data !== 24'h220033 || stage_valid !== 3'b101) begin
            n_err++; $display("FAIL bubble_1 got %h/%b want 220033/101", stage_data, stage_valid); end
        cyc();
        n_cmp++; if (stage_data !== 24'h000033 || stage_valid !== 3'b001) begin
            n_err++; $display("FAIL bubble_2 got %h/%b want 000033/001", stage_data, stage_valid); end
        n_cmp++; if (bubble_cnt !== 4'd2) begin n_err++; $display("FAIL bubble_cnt got %0d want 2", bubble_cnt); end
        stall = '0;
    endtask

    task automatic test_flush_vs_stall();
        logic [W-1:0] words [3];
        words[0] = 8'h44; words[1] = 8'h55; words[2] = 8'h66;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = words[k];
            cyc();
        end
        in_data = 8'h77;
        flush = 3'b010; stall = 3'b010;
        cyc();
        flush = '0; stall = '0;
        n_cmp++; if (stage_data !== 24'h550077 || stage_valid !== 3'b101) begin
            n_err++; $display("FAIL flush_stall got %h/%b want 550077/101", stage_data, stage_valid); end
        n_cmp++; if (bubble_cnt !== 4'd2) begin n_err++; $display("FAIL flush_cnt got %0d want 2", bubble_cnt); end
    endtask

    task automatic test_invalid_input();
        in_valid = 1'b0; in_data = 8'hFF;
        cyc();
        n_cmp++; if (stage_data[7:0] !== 8'h00 || stage_valid[0] !== 1'b0) begin
            n_err++; $display("FAIL invalid_in got %h/%b want 00/0", stage_data[7:0], stage_valid[0]); end
        n_cmp++; if (stage_data[15:8] !== 8'h77 || stage_valid[1] !== 1'b1) begin
            n_err++; $display("FAIL invalid_s1 got %h/%b want 77/1", stage_data[15:8], stage_valid[1]); end
    endtask

    task automatic test_saturation();
        in_valid = 1'b1; in_data = 8'h3C;
        stall = 3'b001;
        for (int k = 0; k < 20; k++) cyc();
        n_cmp++; if (bubble_cnt !== 4'd15) begin n_err++; $display("FAIL saturate got %0d want 15", bubble_cnt); end
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        n_cmp++; if (bubble_cnt !== 4'd0) begin n_err++; $display("FAIL clr_with_bubble got %0d want 0", bubble_cnt); end
        stall = '0;
    endtask

    task automatic test_reset_mid();
        stall = 3'b001; in_valid = 1'b1; in_data = 8'h01;
        cyc();
        stall = '0;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'h90 + 8'(k);
            cyc();
        end
        n_cmp++; if (stage_valid !== 3'b111 || bubble_cnt !== 4'd1) begin
            n_err++; $display("FAIL pre_reset got %b/%0d want 111/1", stage_valid, bubble_cnt); end
        stall = 3'b111; reset = 1'b1;
        cyc();
        reset = 1'b0; stall = '0;
        n_cmp++; if (stage_data !== 24'h000000 || stage_valid !== 3'b000 || bubble_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_mid got %h/%b/%0d want 000000/000/0", stage_data, stage_valid, bubble_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 59) == 0);
            cnt_clr  = ($urandom_range(0, 29) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = 8'($urandom);
            for (int b = 0; b < S; b++) begin
                stall[b] = ($urandom_range(0, 3) == 0);
                flush[b] = ($urandom_range(0, 7) == 0);
            end
            cyc();
            n_cmp++; if (stage_data !== m_data_pk()) begin
                n_err++; $display("FAIL rand_data cyc %0d got %h want %h", k, stage_data, m_data_pk()); end
            n_cmp++; if (stage_valid !== m_vld_pk()) begin
                n_err++; $display("FAIL rand_valid cyc %0d got %b want %b", k, stage_valid, m_vld_pk()); end
            n_cmp++; if (bubble_cnt !== C'(m_cnt)) begin
                n_err++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", k, bubble_cnt, m_cnt); end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < S; i++) begin m_d[i] = 8'h00; m_v[i] = 1'b0; end
        m_cnt = 0;
        idle_inputs();
        #2;
        test_reset();
        test_stream();
        test_stall_bubble();
        test_flush_vs_stall();
        test_invalid_input();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
